alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU (8 ops, 3-bit SELECT, ZERO flag) between two requesters, e.g. the main instruction datapath (port 0) and a secondary/debug issue path (port 1).
- Uses round-robin arbitration and registers the ALU operands and SELECT.
- Waits an op-dependent number of cycles for the ALU's internal delays to settle, then captures RESULT and ZERO and returns them with a one-cycle DONE pulse to the granted requester.

Parameters:
- BASIC_CYCLES, 1, settle cycles for FORWARD/ADD/AND/OR (SELECT 000–011).
- MUL_CYCLES, 3, settle cycles for MULT (100).
- SHIFT_CYCLES, 2, settle cycles for SLL/SRA/ROR (101–111).
- All parameters must be ≥1.

Ports:
- CLK, input, 1, system clock (rising edge).
- RESET, input, 1, asynchronous active-high reset.
- REQ0, input, 1, requester 0 request.
- DATA1_0, input, 8, requester 0 operand 1.
- DATA2_0, input, 8, requester 0 operand 2.
- SEL_0, input, 3, requester 0 ALU opcode.
- REQ1, input, 1, requester 1 request.
- DATA1_1, input, 8, requester 1 operand 1.
- DATA2_1, input, 8, requester 1 operand 2.
- SEL_1, input, 3, requester 1 ALU opcode.
- GNT0, output, 1, one-cycle grant pulse to requester 0.
- GNT1, output, 1, one-cycle grant pulse to requester 1.
- DONE0, output, 1, one-cycle completion pulse to requester 0.
- DONE1, output, 1, one-cycle completion pulse to requester 1.
- RESULT_OUT, output, 8, captured ALU result; held until the next capture.
- ZERO_OUT, output, 1, captured ALU ZERO flag; held until the next capture.
- BUSY, output, 1, high in EXEC or DONE state.
- ALU_DATA1, output, 8, registered operand 1 to the ALU.
- ALU_DATA2, output, 8, registered operand 2 to the ALU.
- ALU_SELECT, output, 3, registered opcode to the ALU.
- ALU_RESULT, input, 8, from ALU RESULT.
- ALU_ZERO, input, 1, from ALU ZERO.

Behaviour:
- Interface rule: one clock, CLK; RESET is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer = requester 0 has priority; settle counter 0.
- States: IDLE, EXEC, DONE. All outputs are registered.
- IDLE:
  - At the rising edge, if any REQ is high, select the winner, latch its DATA1/DATA2/SEL into ALU_DATA1/ALU_DATA2/ALU_SELECT, and load the counter with LAT(SEL)-1.
  - Assert GNTx for the next cycle only, then go to EXEC.
  - If no REQ is high, stay in IDLE.
- Arbitration:
  - If exactly one REQ is high, it wins.
  - If both are high, the pointer's requester wins. The pointer then moves to the other requester (it moves after every grant).
  - Requests are sampled in IDLE only.
- Requester handshake:
  - Hold REQ, operands and SEL stable until GNT is seen.
  - Drop REQ in the GNT cycle unless a further operation is wanted. REQ still high when the arbiter returns to IDLE counts as a new request.
- EXEC:
  - ALU_* outputs are held constant.
  - If the counter is 0 at an edge: capture ALU_RESULT into RESULT_OUT and ALU_ZERO into ZERO_OUT, assert DONEx for the owner, and go to DONE.
  - Otherwise decrement the counter.
- DONE: lasts one cycle, then IDLE; DONEx deasserts.
- Timing:
  - GNT-high cycle to DONE-high cycle = LAT cycles.
  - Back-to-back issue period = LAT+2 cycles.
- Clock period must exceed the ALU's largest per-stage settle delay; the cycle parameters absorb the multi-stage ops.
- Invalid SEL does not exist (all 8 codes are legal).
- RESET mid-operation: immediate abort; no DONE is issued; the in-flight result is lost; the pointer returns to requester 0.
- A requester that drops REQ before GNT is never granted; it is not an error.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs GNT_CNT0[7:0] and GNT_CNT1[7:0], reset to 0.
  - Each increments on its GNTx pulse and saturates at 255.
  - Adds input STATS_CLR, a synchronous clear with priority over increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package:
  - The 3-bit opcode constants (FORWARD=000, ADD=001, AND=010, OR=011, MULT=100, SLL=101, SRA=110, ROR=111).
  - The state encoding (IDLE=0, EXEC=1, DONE=2).
  - A latency function mapping opcode to cycles.
- Sub-module: rr_arb2, a two-input round-robin arbiter holding the pointer and producing a one-hot winner.

Test Plan:
- Reset: assert RESET mid-EXEC of a MULT → all outputs 0 immediately, no DONE0/DONE1 ever, next REQ1-only is granted normally.
- Single ADD: REQ0, DATA1_0=5, DATA2_0=3, SEL_0=001 → GNT0 for 1 cycle, DONE0 1 cycle later, RESULT_OUT=8, ZERO_OUT=0.
- Latency: REQ1 MULT 4×6=24, then REQ1 SLL 0x01 by 2 → DONE1 3 cycles after GNT1 with 24, then 2 cycles after GNT1 with 0x04; BUSY high throughout each op.
- Contention: REQ0 and REQ1 both held for 4 ops (ADD 0x7F+1, AND 0xF0&0x3C) → grants alternate 0,1,0,1; results 0x80 on DONE0 and 0x30 on DONE1.
- Zero flag: REQ0 ADD 0xFF+0x01 (-1+1) → RESULT_OUT=0x00, ZERO_OUT=1; next FORWARD 0x09 → ZERO_OUT=0.
- ALU_ARB_STATS_EN: 300 grants to requester 0 → GNT_CNT0=255; STATS_CLR pulse → 0; without the macro, the bench compiles without the stats ports.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter: ALU opcode constants, the arbiter
// FSM state encoding and the opcode-to-settle-latency mapping.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    // ALU opcodes (3-bit SELECT); all eight codes are legal.
    localparam logic [2:0] OP_FORWARD = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
    localparam logic [2:0] OP_MULT    = 3'b100;
    localparam logic [2:0] OP_SLL     = 3'b101;
    localparam logic [2:0] OP_SRA     = 3'b110;
    localparam logic [2:0] OP_ROR     = 3'b111;

    // Width of the settle counter; latencies up to 256 cycles are representable.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of cycles the ALU needs to settle for a given opcode.
    function automatic logic [CNT_W-1:0] op_latency(
        input logic [2:0] sel,
        input int         basic_cycles,
        input int         mul_cycles,
        input int         shift_cycles
    );
        int w_lat;
        if (sel == OP_MULT) begin
            w_lat = mul_cycles;
        end else if (sel >= OP_SLL) begin
            // SLL, SRA and ROR share the shifter path
            w_lat = shift_cycles;
        end else begin
            w_lat = basic_cycles;
        end
        return CNT_W'(w_lat);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Produces a one-hot winner combinationally
// from the request vector and a priority pointer; the pointer moves to the
// losing side after every accepted grant.
//   i_clk      : clock (rising edge)
//   i_rst      : asynchronous active-high reset (pointer -> requester 0)
//   i_req[1:0] : request vector, bit n = requester n
//   i_advance  : grant accepted this cycle; update the pointer
//   o_gnt[1:0] : one-hot winner (00 when no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

    // After a grant the other requester gets priority: pointer = !winner.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one 8-bit ALU between two requesters. A round-robin winner is picked
// in IDLE, its operands/opcode are registered onto ALU_*, the arbiter waits
// the opcode's settle latency, then captures RESULT/ZERO and pulses DONEx.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   REQx, DATA1_x, DATA2_x,    request, operands and opcode of requester x
//   SEL_x
//   GNTx                       one-cycle grant pulse
//   DONEx                      one-cycle completion pulse
//   RESULT_OUT, ZERO_OUT       captured ALU result/flag, held until next capture
//   BUSY                       high while an operation is in EXEC or DONE
//   ALU_DATA1/2, ALU_SELECT    registered operands/opcode driven to the ALU
//   ALU_RESULT, ALU_ZERO       ALU outputs
// Optional (macro ALU_ARB_STATS_EN):
//   STATS_CLR                  synchronous clear of the grant counters
//   GNT_CNT0, GNT_CNT1         saturating per-requester grant counters
//
// Handshake: a requester raises REQx with DATA1_x/DATA2_x/SEL_x and keeps them
// stable until it sees GNTx. Requests are sampled only while IDLE, so a REQx
// still high when the arbiter returns to IDLE is taken as a new request, and
// a REQx dropped before GNTx is simply never granted. DONEx marks the cycle
// in which RESULT_OUT/ZERO_OUT first hold that requester's result.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int BASIC_CYCLES = 1,
    parameter int MUL_CYCLES   = 3,
    parameter int SHIFT_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [7:0] DATA1_0,
    input  logic [7:0] DATA2_0,
    input  logic [2:0] SEL_0,
    input  logic       REQ1,
    input  logic [7:0] DATA1_1,
    input  logic [7:0] DATA2_1,
    input  logic [2:0] SEL_1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RESULT_OUT,
    output logic       ZERO_OUT,
    output logic       BUSY,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic       STATS_CLR,
    output logic [7:0] GNT_CNT0,
    output logic [7:0] GNT_CNT1
`endif
);

    state_t           r_state,  w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_owner,  w_owner_nxt;   // 1: requester 1 owns the op
    logic             r_gnt0,   w_gnt0_nxt;
    logic             r_gnt1,   w_gnt1_nxt;
    logic             r_done0,  w_done0_nxt;
    logic             r_done1,  w_done1_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_zero,   w_zero_nxt;
    logic [7:0]       r_result, w_result_nxt;
    logic [7:0]       r_data1,  w_data1_nxt;
    logic [7:0]       r_data2,  w_data2_nxt;
    logic [2:0]       r_select, w_select_nxt;

    logic [1:0]       w_req;
    logic [1:0]       w_win;

    // Requests are only visible to the arbiter while IDLE.
    assign w_req = {REQ1, REQ0} & {2{r_state == ST_IDLE}};

    rr_arb2 u_rr_arb2 (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_req     (w_req),
        .i_advance (|w_win),
        .o_gnt     (w_win)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_owner_nxt  = r_owner;
        w_gnt0_nxt   = 1'b0;
        w_gnt1_nxt   = 1'b0;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_zero_nxt   = r_zero;
        w_result_nxt = r_result;
        w_data1_nxt  = r_data1;
        w_data2_nxt  = r_data2;
        w_select_nxt = r_select;

        case (r_state)
            ST_IDLE: begin
                if (|w_win) begin
                    w_owner_nxt = w_win[1];
                    if (w_win[1]) begin
                        w_data1_nxt  = DATA1_1;
                        w_data2_nxt  = DATA2_1;
                        w_select_nxt = SEL_1;
                        w_gnt1_nxt   = 1'b1;
                    end else begin
                        w_data1_nxt  = DATA1_0;
                        w_data2_nxt  = DATA2_0;
                        w_select_nxt = SEL_0;
                        w_gnt0_nxt   = 1'b1;
                    end
                    // The GNT cycle is the first settle cycle, hence LAT-1.
                    w_cnt_nxt   = op_latency(w_select_nxt, BASIC_CYCLES, MUL_CYCLES,
                                             SHIFT_CYCLES) - CNT_W'(1);
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_result_nxt = ALU_RESULT;
                    w_zero_nxt   = ALU_ZERO;
                    w_done0_nxt  = ~r_owner;
                    w_done1_nxt  = r_owner;
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_owner  <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= '0;
            r_data1  <= '0;
            r_data2  <= '0;
            r_select <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_owner  <= w_owner_nxt;
            r_gnt0   <= w_gnt0_nxt;
            r_gnt1   <= w_gnt1_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_busy   <= w_busy_nxt;
            r_zero   <= w_zero_nxt;
            r_result <= w_result_nxt;
            r_data1  <= w_data1_nxt;
            r_data2  <= w_data2_nxt;
            r_select <= w_select_nxt;
        end
    end

    assign GNT0       = r_gnt0;
    assign GNT1       = r_gnt1;
    assign DONE0      = r_done0;
    assign DONE1      = r_done1;
    assign BUSY       = r_busy;
    assign RESULT_OUT = r_result;
    assign ZERO_OUT   = r_zero;
    assign ALU_DATA1  = r_data1;
    assign ALU_DATA2  = r_data2;
    assign ALU_SELECT = r_select;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] r_gnt_cnt0;
    logic [7:0] r_gnt_cnt1;

    // Counts on the registered GNT pulse; clear wins over increment.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else if (STATS_CLR) begin
            r_gnt_cnt0 <= '0;
            r_gnt_cnt1 <= '0;
        end else begin
            if (r_gnt0 && (r_gnt_cnt0 != 8'hFF)) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
            end
            if (r_gnt1 && (r_gnt_cnt1 != 8'hFF)) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
            end
        end
    end

    assign GNT_CNT0 = r_gnt_cnt0;
    assign GNT_CNT1 = r_gnt_cnt1;
`endif

endmodule
